// File: rtl/bp_cce_stall_unit_gen.sv
// bp_cce_stall_unit_gen
// Parametrised stall unit for the CCE microcode engine. It produces a same-cycle
// stall that blocks architectural updates and forces replay. It also keeps
// episode statistics: consecutive and total stall counters, the cause vector
// seen on the first cycle of an episode, and a watchdog that flags a hung engine.
module bp_cce_stall_unit_gen #(
    parameter int num_src_q_p       = 4,
    parameter int num_dst_q_p       = 2,
    parameter int num_fu_p          = 7,
    parameter int max_counter_val_p = 255,
    parameter int watchdog_cycles_p = 128
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       inst_v_i,
    input  logic [num_src_q_p-1:0]                     src_yumi_i,
    input  logic [num_src_q_p-1:0]                     src_v_i,
    input  logic [num_dst_q_p-1:0]                     dst_v_i,
    input  logic [num_dst_q_p-1:0]                     dst_ready_i,
    input  logic                                       wfq_v_i,
    input  logic [num_src_q_p-1:0]                     wfq_mask_i,
    input  logic [num_fu_p-1:0]                        fu_use_i,
    input  logic [num_fu_p-1:0]                        fu_busy_i,
    input  logic                                       global_busy_i,
    input  logic                                       clr_i,
    output logic                                       stall_o,
    output logic [4:0]                                 cause_o,
    output logic [4:0]                                 first_cause_o,
    output logic [$clog2(max_counter_val_p+1)-1:0]     stall_count_o,
    output logic [$clog2(max_counter_val_p+1)-1:0]     total_stall_o,
    output logic                                       hang_o
);

    localparam int cnt_w_lp = $clog2(max_counter_val_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(max_counter_val_p);
    // Value of the consecutive counter during the stall cycle that completes
    // the watchdog window; the edge ending that cycle declares the hang.
    localparam logic [cnt_w_lp-1:0] wd_last_lp = cnt_w_lp'(watchdog_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HANG  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Per-queue / per-unit hazard terms
    // ------------------------------------------------------------------
    logic [num_src_q_p-1:0] src_empty_terms;
    logic [num_src_q_p-1:0] wfq_ready_terms;
    logic [num_dst_q_p-1:0] dst_full_terms;
    logic [num_fu_p-1:0]    fu_hazard_terms;

    genvar gi;
    generate
        for (gi = 0; gi < num_src_q_p; gi++) begin : g_src
            // dequeue from an empty queue
            assign src_empty_terms[gi] = src_yumi_i[gi] & ~src_v_i[gi];
            // a queue the wait-for-queue instruction cares about has data
            assign wfq_ready_terms[gi] = wfq_mask_i[gi] & src_v_i[gi];
        end
        for (gi = 0; gi < num_dst_q_p; gi++) begin : g_dst
            // enqueue into a destination that cannot accept
            assign dst_full_terms[gi] = dst_v_i[gi] & ~dst_ready_i[gi];
        end
        for (gi = 0; gi < num_fu_p; gi++) begin : g_fu
            // instruction needs a resource another unit currently holds
            assign fu_hazard_terms[gi] = fu_use_i[gi] & fu_busy_i[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational cause vector and stall
    // ------------------------------------------------------------------
    logic [4:0] cause;
    logic       stall;

    // Instruction-related causes only count with a valid instruction; the
    // global blocker stalls the engine regardless.
    always_comb begin
        cause    = '0;
        cause[0] = inst_v_i & (|src_empty_terms);
        cause[1] = inst_v_i & (|dst_full_terms);
        cause[2] = inst_v_i & wfq_v_i & ~(|wfq_ready_terms);
        cause[3] = global_busy_i;
        cause[4] = inst_v_i & (|fu_hazard_terms);
    end

    assign stall   = |cause;
    assign stall_o = stall;
    assign cause_o = cause;

    // ------------------------------------------------------------------
    // Sequential tracking
    // ------------------------------------------------------------------
    state_e                state_reg;
    logic [cnt_w_lp-1:0]   stall_count_reg;
    logic [cnt_w_lp-1:0]   total_stall_reg;
    logic [4:0]            first_cause_reg;
    logic                  hang_reg;

    logic [cnt_w_lp-1:0]   stall_count_next;
    logic [cnt_w_lp-1:0]   total_stall_next;

    // Saturating increments for both counters
    always_comb begin
        stall_count_next = stall_count_reg;
        total_stall_next = total_stall_reg;
        if (stall_count_reg != cnt_max_lp) begin
            stall_count_next = stall_count_reg + cnt_one_lp;
        end
        if (total_stall_reg != cnt_max_lp) begin
            total_stall_next = total_stall_reg + cnt_one_lp;
        end
    end

    // Episode FSM with registered outputs; clear outranks any same-cycle update
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clr_i) begin
            state_reg       <= RUN;
            stall_count_reg <= '0;
            total_stall_reg <= '0;
            first_cause_reg <= '0;
            hang_reg        <= 1'b0;
        end else begin
            if (stall) begin
                total_stall_reg <= total_stall_next;
            end
            case (state_reg)
                RUN: begin
                    if (stall) begin
                        first_cause_reg <= cause;
                        stall_count_reg <= cnt_one_lp;
                        if (watchdog_cycles_p == 1) begin
                            state_reg <= HANG;
                            hang_reg  <= 1'b1;
                        end else begin
                            state_reg <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state_reg       <= RUN;
                        stall_count_reg <= '0;
                    end else begin
                        stall_count_reg <= stall_count_next;
                        if (stall_count_reg == wd_last_lp) begin
                            state_reg <= HANG;
                            hang_reg  <= 1'b1;
                        end
                    end
                end
                HANG: begin
                    // Hang is sticky; episodes are still tracked so software
                    // can inspect them after the watchdog has fired.
                    if (!stall) begin
                        stall_count_reg <= '0;
                    end else if (stall_count_reg == '0) begin
                        first_cause_reg <= cause;
                        stall_count_reg <= cnt_one_lp;
                    end else begin
                        stall_count_reg <= stall_count_next;
                    end
                end
                default: begin
                    state_reg       <= RUN;
                    stall_count_reg <= '0;
                end
            endcase
        end
    end

    assign stall_count_o = stall_count_reg;
    assign total_stall_o = total_stall_reg;
    assign first_cause_o = first_cause_reg;
    assign hang_o        = hang_reg;

endmodule

// File: doc/bp_cce_stall_unit_gen.md
# bp_cce_stall_unit_gen

Parametrised stall unit for the CCE microcode engine, generalising the fixed four-input-queue / two-output-queue stall logic to arbitrary queue and functional-unit counts. It produces the same-cycle stall that blocks architectural state updates and forces instruction replay. It also adds sequential tracking:

- a saturating consecutive-stall counter;
- a saturating total-stall counter;
- a per-episode cause capture;
- a watchdog state machine that flags a hung engine.

It sits between the decoder/functional units and the PC/commit logic.

## Interface
Parameters:
- num_src_q_p, 4, number of input queues (receive/yumi and wait-for-queue sources)
- num_dst_q_p, 2, number of output queues (send/valid sources)
- num_fu_p, 7, number of functional-unit structural-hazard pairs
- max_counter_val_p, 255, saturation value of both stall counters
- watchdog_cycles_p, 128, consecutive stall cycles that declare a hang; legal range is 1..max_counter_val_p

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_n_i  in  1  reset, synchronous, active-low
- inst_v_i  in  1  decoded instruction valid this cycle
- src_yumi_i  in  num_src_q_p  instruction dequeues source q[i]
- src_v_i  in  num_src_q_p  source q[i] has valid data
- dst_v_i  in  num_dst_q_p  instruction enqueues destination q[j]
- dst_ready_i  in  num_dst_q_p  destination q[j] ready
- wfq_v_i  in  1  instruction is wait-for-queue
- wfq_mask_i  in  num_src_q_p  queues wfq waits on
- fu_use_i  in  num_fu_p  instruction uses resource k
- fu_busy_i  in  num_fu_p  resource k held by another unit
- global_busy_i  in  1  OR of unconditional blockers (dir busy, msg busy)
- clr_i  in  1  clear counters, sticky state and watchdog
- stall_o  out  1  stall this cycle
- cause_o  out  5  current-cycle cause vector
- first_cause_o  out  5  cause vector captured on the first cycle of the current/last episode
- stall_count_o  out  clog2(max_counter_val_p+1)  consecutive stall cycles
- total_stall_o  out  clog2(max_counter_val_p+1)  total stall cycles since reset/clear
- hang_o  out  1  watchdog fired, sticky

## Operation
Cause bits are computed combinationally and are each gated by inst_v_i, except bit 3:
- cause[0] src empty: |(src_yumi_i & ~src_v_i)
- cause[1] dst full: |(dst_v_i & ~dst_ready_i)
- cause[2] wfq: wfq_v_i & ~|(wfq_mask_i & src_v_i)
- cause[3] global: global_busy_i; this bit is not gated by inst_v_i
- cause[4] fu hazard: |(fu_use_i & fu_busy_i)

stall_o = |cause_o. cause_o equals the cause vector.

FSM states and transitions:
- RUN: if stall_o, go to STALL, capture first_cause_o <= cause_o, and set stall_count <= 1.
- STALL:
  - if ~stall_o, go to RUN and set stall_count <= 0;
  - else increment stall_count, saturating;
  - if stall_o and stall_count == watchdog_cycles_p-1, go to HANG and set hang_o.
  - If watchdog_cycles_p == 1, the RUN→STALL entry goes directly to HANG.
- HANG: stall_count keeps saturating while stalled and returns to 0 when not stalled. hang_o stays 1 until clr_i or reset. stall_o is never forced by HANG.

Counters and clear:
- total_stall increments, saturating at max_counter_val_p, on every stall_o cycle in any state.
- clr_i returns the FSM to RUN and zeroes stall_count, total_stall, first_cause_o and hang_o.
- clr_i has priority over any same-cycle increment or capture. stall_o is still computed that cycle, but it is not counted.
- A new stall episode overwrites first_cause_o on its entry cycle.

## Timing
- stall_o and cause_o are purely combinational, with zero latency from the inputs.
- Counters, first_cause_o, hang_o and the FSM update on the rising edge following the stall cycle. stall_count_o reads N after N consecutive stall cycles.
- hang_o rises on the edge that ends stall cycle number watchdog_cycles_p.
- Reset (reset_n_i low at an edge) takes effect mid-episode. After reset:
  - FSM is RUN;
  - stall_count_o, total_stall_o, first_cause_o and hang_o are all 0.
  - stall_o and cause_o follow the inputs even during reset.
- Saturation: counters hold at max_counter_val_p and never wrap.

## Test plan
- Source empty: inst_v=1, src_yumi=4'b0010, src_v=4'b0000 for 3 cycles, then src_v=4'b0010 → stall_o=1 for 3 cycles, cause_o=5'b00001, first_cause_o=5'b00001, stall_count_o reads 1,2,3 then 0, total_stall_o=3.
- WFQ mask: wfq_v=1, wfq_mask=4'b1001, src_v=4'b0110 → stall_o=1 with cause[2]=1; src_v=4'b1000 → stall_o=0.
- Watchdog: watchdog_cycles_p=4, global_busy=1 held for 6 cycles → hang_o rises after cycle 4 and stays 1 after busy drops; clr_i=1 → hang_o=0, total_stall_o=0.
- Saturation: max_counter_val_p=7, continuous stall for 10 cycles → stall_count_o=7 and total_stall_o=7 with no wrap.
- Simultaneous causes plus clear: dst_v=2'b01 with dst_ready=0, fu_use=fu_busy=1 on bit 3, and clr_i asserted on the episode's first cycle → stall_o=1, cause_o=5'b10010, FSM stays RUN, counters remain 0, first_cause_o=0; next cycle without clr_i → first_cause_o=5'b10010.
- Reset mid-episode: 5 stall cycles, then reset_n_i=0 for one edge → all registered outputs 0, and with stall still asserted stall_count_o restarts at 1.
